// File: rtl/relay_mode_ctrl_if.sv
// Signal bundle between the relay selector, relay PHY, link datapath and relay_mode_ctrl.
// switch_count is present only when RELAY_STATS_EN is defined.
interface relay_mode_ctrl_if;
  logic [1:0]  sel_in;
  logic        link_busy;
  logic        switch_ack;
  logic        switch_req;
  logic [1:0]  target_mode;
  logic [1:0]  mode;
  logic        mode_valid;
  logic        abort_pulse;
`ifdef RELAY_STATS_EN
  logic [15:0] switch_count;
`endif

  modport master (
    output sel_in, link_busy, switch_ack,
    input  switch_req, target_mode, mode, mode_valid, abort_pulse
`ifdef RELAY_STATS_EN
    , input switch_count
`endif
  );

  modport slave (
    input  sel_in, link_busy, switch_ack,
    output switch_req, target_mode, mode, mode_valid, abort_pulse
`ifdef RELAY_STATS_EN
    , output switch_count
`endif
  );
endinterface

// File: rtl/relay_mode_ctrl.sv
// Confirms relay_sel decisions and sequences the drain/request/guard switch with the relay PHY.
// Optional RELAY_STATS_EN adds a saturating count of committed switches.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_ACTIVE | mode valid, confirming a differing sel_in
// ST_DRAIN  | switch committed, waiting for link_busy to drop
// ST_REQ    | switch_req high, waiting for switch_ack or timeout
// ST_GUARD  | PHY acked, idle settle before the new mode goes valid
module relay_mode_ctrl #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int GUARD_CYCLES   = 8,
  parameter int ACK_TIMEOUT    = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  relay_mode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_REQ, ST_GUARD} state_e;

  localparam logic [CNT_W-1:0] CONFIRM_N = CNT_W'(CONFIRM_CYCLES);
  localparam logic [CNT_W-1:0] GUARD_N   = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] TIMEOUT_N = CNT_W'(ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  state_e           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [1:0]       target_q, target_d;
  logic [1:0]       cand_q, cand_d;
  logic             valid_q, valid_d;
  logic             req_q, req_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] confirm_q, confirm_d;
  logic [CNT_W-1:0] guard_q, guard_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
`ifdef RELAY_STATS_EN
  logic [15:0]      count_q, count_d;
`endif

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    target_d  = target_q;
    cand_d    = cand_q;
    valid_d   = valid_q;
    req_d     = req_q;
    abort_d   = 1'b0;
    confirm_d = confirm_q;
    guard_d   = guard_q;
    timeout_d = timeout_q;
`ifdef RELAY_STATS_EN
    count_d   = count_q;
`endif
    case (state_q)
      ST_ACTIVE: begin
        if (bus.sel_in == mode_q || bus.sel_in == 2'b11) begin
          confirm_d = '0;
        end else if (bus.sel_in != cand_q) begin
          cand_d    = bus.sel_in;
          confirm_d = ONE;
        end else if (confirm_q < CONFIRM_N) begin
          confirm_d = confirm_q + ONE;
        end
        if (confirm_d == CONFIRM_N) begin
          target_d = cand_d;
          valid_d  = 1'b0;
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!bus.link_busy) begin
          req_d     = 1'b1;
          timeout_d = '0;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        timeout_d = timeout_q + ONE;
        // Ack is checked first so a late ack on the expiry cycle still completes the switch.
        if (bus.switch_ack) begin
          req_d   = 1'b0;
          guard_d = '0;
          state_d = ST_GUARD;
        end else if (timeout_d == TIMEOUT_N) begin
          req_d     = 1'b0;
          abort_d   = 1'b1;
          valid_d   = 1'b1;
          cand_d    = 2'b00;
          confirm_d = '0;
          state_d   = ST_ACTIVE;
        end
      end
      ST_GUARD: begin
        guard_d = guard_q + ONE;
        if (guard_d == GUARD_N) begin
          mode_d    = target_q;
          valid_d   = 1'b1;
          cand_d    = 2'b00;
          confirm_d = '0;
          state_d   = ST_ACTIVE;
`ifdef RELAY_STATS_EN
          if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`endif
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACTIVE;
      mode_q    <= 2'b00;
      target_q  <= 2'b00;
      cand_q    <= 2'b00;
      valid_q   <= 1'b1;
      req_q     <= 1'b0;
      abort_q   <= 1'b0;
      confirm_q <= '0;
      guard_q   <= '0;
      timeout_q <= '0;
`ifdef RELAY_STATS_EN
      count_q   <= 16'd0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      target_q  <= target_d;
      cand_q    <= cand_d;
      valid_q   <= valid_d;
      req_q     <= req_d;
      abort_q   <= abort_d;
      confirm_q <= confirm_d;
      guard_q   <= guard_d;
      timeout_q <= timeout_d;
`ifdef RELAY_STATS_EN
      count_q   <= count_d;
`endif
    end
  end

  assign bus.switch_req  = req_q;
  assign bus.target_mode = target_q;
  assign bus.mode        = mode_q;
  assign bus.mode_valid  = valid_q;
  assign bus.abort_pulse = abort_q;
`ifdef RELAY_STATS_EN
  assign bus.switch_count = count_q;
`endif

endmodule

// File: tb/tb_relay_mode_ctrl.sv
// Self-checking bench for relay_mode_ctrl: directed scenarios with literal expectations,
// then random stimulus against a timeline model of the confirm/drain/request/guard rules.
module tb_relay_mode_ctrl;
  localparam int CONFIRM = 4;
  localparam int GUARD   = 8;
  localparam int TO      = 16;

  logic clk;
  logic rst_n;
  relay_mode_ctrl_if bus ();

  relay_mode_ctrl #(
    .CONFIRM_CYCLES(CONFIRM), .GUARD_CYCLES(GUARD), .ACK_TIMEOUT(TO), .CNT_W(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: a switch is committed once the last CONFIRM legal, non-current
  // decisions seen while active are all the same value; the rest is timed by edge stamps.
  logic [1:0]  hist[$];
  logic [1:0]  m_mode, m_target;
  logic        m_valid, m_req, m_abort;
  logic [15:0] m_count;
  int          phase;   // 0 active, 1 waiting for link, 2 awaiting ack, 3 settling
  int          cyc, t_req, t_ack;

  function automatic bit all_same();
    for (int i = 1; i < hist.size(); i++)
      if (hist[i] != hist[0]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 2'b00; m_target = 2'b00; m_valid = 1'b1; m_req = 1'b0;
    m_abort = 1'b0; m_count = 16'd0; phase = 0; hist.delete();
  endtask

  task automatic model_step();
    cyc = cyc + 1;
    m_abort = 1'b0;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (phase)
        0: begin
          if (bus.sel_in == 2'b11 || bus.sel_in == m_mode) begin
            hist.delete();
          end else begin
            hist.push_back(bus.sel_in);
            if (hist.size() > CONFIRM) void'(hist.pop_front());
            if (hist.size() == CONFIRM && all_same()) begin
              m_target = bus.sel_in; m_valid = 1'b0; phase = 1; hist.delete();
            end
          end
        end
        1: if (!bus.link_busy) begin m_req = 1'b1; t_req = cyc; phase = 2; end
        2: begin
          if (bus.switch_ack) begin
            m_req = 1'b0; t_ack = cyc; phase = 3;
          end else if (cyc - t_req == TO) begin
            m_req = 1'b0; m_abort = 1'b1; m_valid = 1'b1; phase = 0;
          end
        end
        default: begin
          if (cyc - t_ack == GUARD) begin
            m_mode = m_target; m_valid = 1'b1; phase = 0;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          end
        end
      endcase
    end
  endtask

  initial begin
    cyc = 0; t_req = 0; t_ack = 0;
    model_reset();
  end

  always @(posedge clk) model_step();

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare_model();
    check("mdl_mode",        16'(bus.mode),        16'(m_mode));
    check("mdl_mode_valid",  16'(bus.mode_valid),  16'(m_valid));
    check("mdl_switch_req",  16'(bus.switch_req),  16'(m_req));
    check("mdl_abort_pulse", 16'(bus.abort_pulse), 16'(m_abort));
    check("mdl_target_mode", 16'(bus.target_mode), 16'(m_target));
`ifdef RELAY_STATS_EN
    check("mdl_switch_count", bus.switch_count, m_count);
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      compare_model();
    end
  endtask

  int ack_pct;

  initial begin
    rst_n = 1'b0;
    bus.sel_in = 2'b00; bus.link_busy = 1'b0; bus.switch_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    compare_model();
    check("rst_mode", 16'(bus.mode), 16'h0);
    check("rst_valid", 16'(bus.mode_valid), 16'h1);
    check("rst_req", 16'(bus.switch_req), 16'h0);
    rst_n = 1'b1;

    // Idle with the current decision: nothing happens.
    tick(20);
    check("idle_mode", 16'(bus.mode), 16'h0);
    check("idle_valid", 16'(bus.mode_valid), 16'h1);

    // Plain switch to 01, ack after 3 request cycles.
    bus.sel_in = 2'b01;
    tick(3);
    check("sw1_valid_pre", 16'(bus.mode_valid), 16'h1);
    tick(1);
    check("sw1_valid_fall", 16'(bus.mode_valid), 16'h0);
    check("sw1_target", 16'(bus.target_mode), 16'h1);
    tick(1);
    check("sw1_req_rise", 16'(bus.switch_req), 16'h1);
    tick(2);
    bus.switch_ack = 1'b1;
    tick(1);
    bus.switch_ack = 1'b0;
    check("sw1_req_drop", 16'(bus.switch_req), 16'h0);
    tick(7);
    check("sw1_guard_wait", 16'(bus.mode_valid), 16'h0);
    tick(1);
    check("sw1_mode", 16'(bus.mode), 16'h1);
    check("sw1_valid", 16'(bus.mode_valid), 16'h1);
`ifdef RELAY_STATS_EN
    check("sw1_count", bus.switch_count, 16'd1);
`endif

    // 01,01,01 (current mode) then 10 x4.
    tick(3);
    bus.sel_in = 2'b10;
    tick(3);
    check("sw2_no_commit", 16'(bus.mode_valid), 16'h1);
    tick(1);
    check("sw2_commit", 16'(bus.mode_valid), 16'h0);
    check("sw2_target", 16'(bus.target_mode), 16'h2);
    tick(1);
    bus.switch_ack = 1'b1;
    tick(1);
    bus.switch_ack = 1'b0;
    tick(8);
    check("sw2_mode", 16'(bus.mode), 16'h2);

    // Commit while the link is busy, then let the request time out.
    bus.link_busy = 1'b1;
    bus.sel_in = 2'b00;
    tick(4);
    check("busy_commit", 16'(bus.mode_valid), 16'h0);
    tick(5);
    check("busy_hold_req", 16'(bus.switch_req), 16'h0);
    bus.link_busy = 1'b0;
    tick(1);
    check("busy_req_rise", 16'(bus.switch_req), 16'h1);
    bus.sel_in = 2'b10;
    tick(15);
    check("to_req_held", 16'(bus.switch_req), 16'h1);
    check("to_no_abort", 16'(bus.abort_pulse), 16'h0);
    tick(1);
    check("to_abort", 16'(bus.abort_pulse), 16'h1);
    check("to_req_drop", 16'(bus.switch_req), 16'h0);
    check("to_mode_kept", 16'(bus.mode), 16'h2);
    check("to_valid", 16'(bus.mode_valid), 16'h1);
    tick(1);
    check("to_abort_1cyc", 16'(bus.abort_pulse), 16'h0);
`ifdef RELAY_STATS_EN
    check("to_count", bus.switch_count, 16'd2);
`endif

    // Illegal decisions never commit, and they restart confirmation.
    bus.sel_in = 2'b11;
    tick(10);
    check("ill_valid", 16'(bus.mode_valid), 16'h1);
    bus.sel_in = 2'b01; tick(1);
    bus.sel_in = 2'b11; tick(1);
    bus.sel_in = 2'b01; tick(3);
    check("ill_restart", 16'(bus.mode_valid), 16'h1);
    tick(1);
    check("ill_commit", 16'(bus.mode_valid), 16'h0);

    // Reset in the middle of the guard interval.
    tick(1);
    bus.switch_ack = 1'b1;
    tick(1);
    bus.switch_ack = 1'b0;
    tick(3);
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_mode", 16'(bus.mode), 16'h0);
    check("mid_rst_valid", 16'(bus.mode_valid), 16'h1);
    check("mid_rst_target", 16'(bus.target_mode), 16'h0);
    check("mid_rst_req", 16'(bus.switch_req), 16'h0);
`ifdef RELAY_STATS_EN
    check("mid_rst_count", bus.switch_count, 16'd0);
`endif
    rst_n = 1'b1;
    bus.sel_in = 2'b00;
    tick(2);

    // Random decision stream, link activity and PHY acks.
    ack_pct = 20;
    for (int i = 0; i < 4000; i++) begin
      if (i % 400 == 0) ack_pct = $urandom_range(0, 30);
      if ($urandom_range(0, 5) == 0) bus.sel_in = 2'($urandom_range(0, 3));
      bus.link_busy  = ($urandom_range(0, 3) == 0);
      bus.switch_ack = (ack_pct > $urandom_range(0, 99));
      rst_n          = ($urandom_range(0, 799) != 0);
      tick(1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
